multislope_seq: RTL and testbench

- Run-up / run-down sequencer for the multi-slope integrating converter.
- Drives the PWM generator's enable, mode and reload inputs.
- Samples the integrator comparator at each PWM period boundary to pick the next period's mode.
- After run-up, runs the integrator back to zero, times the run-down, and hands the mode-A count, mode-B count and run-down count to the host with a valid/ready handshake.

---
 rtl/multislope_seq.sv | 175 +++++++++++++++++
 tb/tb_multislope_seq.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/multislope_seq.sv
// ---------------------------------------------------------------------------
// multislope_seq: run-up/run-down sequencer for a multi-slope integrating ADC.
// Optional macro COMP_SYNC_EN adds a 2-flop comparator synchroniser. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module multislope_seq #(
  parameter int PERIOD       = 259,
  parameter int RUNUP_CYCLES = 1000,
  parameter int RUNDOWN_MAX  = 4095,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             comp,
  input  logic             result_ready,
  output logic             pwm_en,
  output logic             pwm_mode,
  output logic             pwm_reload,
  output logic             rd_pos,
  output logic             rd_neg,
  output logic             busy,
  output logic             result_valid,
  output logic [CNT_W-1:0] n_a,
  output logic [CNT_W-1:0] n_b,
  output logic [15:0]      rd_cnt,
  output logic             rd_timeout,
  output logic             rd_dir
);

  localparam int              PC_W    = $clog2(PERIOD);
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PERIOD - 1);
  localparam logic [15:0]     PN_LAST = 16'(RUNUP_CYCLES - 1);
  localparam logic [15:0]     RD_MAX  = 16'(RUNDOWN_MAX);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUNUP   = 2'd1,
    S_RUNDOWN = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  logic comp_s;

`ifdef COMP_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= 2'b00;
    else      sync_q <= {sync_q[0], comp};
  end

  assign comp_s = sync_q[1];
`else
  assign comp_s = comp;
`endif

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [15:0]       pn_q, pn_d;
  logic [CNT_W-1:0]  n_a_q, n_a_d;
  logic [CNT_W-1:0]  n_b_q, n_b_d;
  logic [15:0]       rd_cnt_q, rd_cnt_d;
  logic              rd_timeout_q, rd_timeout_d;
  logic              rd_dir_q, rd_dir_d;
  logic              pwm_mode_q, pwm_mode_d;
  logic              boundary;

  assign boundary = (state_q == S_RUNUP) && (pc_q == PC_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      pn_q         <= '0;
      n_a_q        <= '0;
      n_b_q        <= '0;
      rd_cnt_q     <= '0;
      rd_timeout_q <= 1'b0;
      rd_dir_q     <= 1'b0;
      pwm_mode_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pn_q         <= pn_d;
      n_a_q        <= n_a_d;
      n_b_q        <= n_b_d;
      rd_cnt_q     <= rd_cnt_d;
      rd_timeout_q <= rd_timeout_d;
      rd_dir_q     <= rd_dir_d;
      pwm_mode_q   <= pwm_mode_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pn_d         = pn_q;
    n_a_d        = n_a_q;
    n_b_d        = n_b_q;
    rd_cnt_d     = rd_cnt_q;
    rd_timeout_d = rd_timeout_q;
    rd_dir_d     = rd_dir_q;
    pwm_mode_d   = pwm_mode_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_a_d        = '0;
          n_b_d        = '0;
          rd_cnt_d     = '0;
          rd_timeout_d = 1'b0;
          rd_dir_d     = 1'b0;
          pwm_mode_d   = 1'b0;
          pc_d         = '0;
          pn_d         = '0;
          state_d      = S_RUNUP;
        end
      end

      S_RUNUP: begin
        if (boundary) begin
          pc_d = '0;
          pn_d = pn_q + 16'd1;
          if (pwm_mode_q) n_b_d = n_b_q + CNT_W'(1);
          else            n_a_d = n_a_q + CNT_W'(1);
          pwm_mode_d = comp_s;
          // The final boundary sample picks the run-down polarity, so the
          // reference switch is valid from the first run-down cycle.
          if (pn_q == PN_LAST) begin
            pwm_mode_d = 1'b0;
            rd_dir_d   = comp_s;
            state_d    = S_RUNDOWN;
          end
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end

      S_RUNDOWN: begin
        if (comp_s != rd_dir_q) begin
          state_d = S_DONE;
        end else if (rd_cnt_q == RD_MAX) begin
          rd_timeout_d = 1'b1;
          state_d      = S_DONE;
        end else begin
          rd_cnt_d = rd_cnt_q + 16'd1;
        end
      end

      S_DONE: begin
        if (result_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign pwm_en       = (state_q == S_RUNUP);
  assign pwm_mode     = pwm_mode_q;
  assign pwm_reload   = boundary;
  assign rd_pos       = (state_q == S_RUNDOWN) && !rd_dir_q;
  assign rd_neg       = (state_q == S_RUNDOWN) &&  rd_dir_q;
  assign busy         = (state_q != S_IDLE);
  assign result_valid = (state_q == S_DONE);
  assign n_a          = n_a_q;
  assign n_b          = n_b_q;
  assign rd_cnt       = rd_cnt_q;
  assign rd_timeout   = rd_timeout_q;
  assign rd_dir       = rd_dir_q;

endmodule

`default_nettype wire

// File: tb/tb_multislope_seq.sv
// Directed, table-driven bench for multislope_seq (PERIOD=10, RUNUP_CYCLES=4, RUNDOWN_MAX=20).
`default_nettype none

module tb_multislope_seq;

  localparam int PERIOD = 10;
  localparam int RUNUP  = 4;
  localparam int RDMAX  = 20;
  localparam int CNT_W  = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             comp = 1'b0;
  logic             result_ready = 1'b0;
  logic             pwm_en, pwm_mode, pwm_reload, rd_pos, rd_neg, busy, result_valid;
  logic [CNT_W-1:0] n_a, n_b;
  logic [15:0]      rd_cnt;
  logic             rd_timeout, rd_dir;

  multislope_seq #(
    .PERIOD(PERIOD), .RUNUP_CYCLES(RUNUP), .RUNDOWN_MAX(RDMAX), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .comp(comp), .result_ready(result_ready),
    .pwm_en(pwm_en), .pwm_mode(pwm_mode), .pwm_reload(pwm_reload),
    .rd_pos(rd_pos), .rd_neg(rd_neg), .busy(busy), .result_valid(result_valid),
    .n_a(n_a), .n_b(n_b), .rd_cnt(rd_cnt), .rd_timeout(rd_timeout), .rd_dir(rd_dir)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       comp_init;
    int         cross_at;   // run-down cycle in which comp crosses; -1 = never
    logic       midstart;   // pulse start during run-up
    logic [3:0] exp_modes;  // bit i = pwm_mode during period i
    int         exp_na;
    int         exp_nb;
    int         exp_cnt;
    logic       exp_to;
    logic       exp_dir;
  } vec_t;

  vec_t vecs[6];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_conv(input int i, input bit ack);
    vec_t       v;
    int         cyc, nrel, k;
    logic [3:0] modes;
    bit         spacing_bad, sw_bad;
    v = vecs[i];
    modes = '0; nrel = 0; spacing_bad = 0; sw_bad = 0;
    @(negedge clk); comp = v.comp_init; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk($sformatf("v%0d_runup_entry", i), {61'd0, busy, pwm_en, pwm_mode}, 64'b110);
    cyc = 0;
    while (!(rd_pos | rd_neg) && cyc < 200) begin
      if (pwm_reload) begin
        if (nrel < 4) modes[nrel] = pwm_mode;
        if (cyc != 9 + 10 * nrel) spacing_bad = 1;
        nrel++;
      end
      start = (v.midstart && cyc == 15);
      @(negedge clk); cyc++;
    end
    start = 1'b0;
    chk($sformatf("v%0d_runup_len", i), 64'(cyc), 64'd40);
    chk($sformatf("v%0d_reloads", i), 64'(nrel), 64'd4);
    chk($sformatf("v%0d_reload_spacing", i), {63'd0, spacing_bad}, 64'd0);
    chk($sformatf("v%0d_modes", i), {60'd0, modes}, {60'd0, v.exp_modes});
    chk($sformatf("v%0d_rd_pwm_off", i), {62'd0, pwm_en, pwm_mode}, 64'd0);
    k = 0;
    while ((rd_pos | rd_neg) && k < 100) begin
      if (rd_neg !== v.exp_dir || rd_pos !== !v.exp_dir) sw_bad = 1;
      if (k == v.cross_at) comp = ~comp;
      @(negedge clk); k++;
    end
    chk($sformatf("v%0d_rd_switch", i), {63'd0, sw_bad}, 64'd0);
    chk($sformatf("v%0d_done_flags", i), {62'd0, result_valid, busy}, 64'b11);
    chk($sformatf("v%0d_n_a", i), 64'(n_a), 64'(v.exp_na));
    chk($sformatf("v%0d_n_b", i), 64'(n_b), 64'(v.exp_nb));
    chk($sformatf("v%0d_rd_cnt", i), 64'(rd_cnt), 64'(v.exp_cnt));
    chk($sformatf("v%0d_to_dir", i), {62'd0, rd_timeout, rd_dir}, {62'd0, v.exp_to, v.exp_dir});
    if (ack) begin
      result_ready = 1'b1;
      @(negedge clk); result_ready = 1'b0;
      chk($sformatf("v%0d_ack_idle", i), {62'd0, result_valid, busy}, 64'd0);
    end
  endtask

  initial begin
    bit ok;
    vecs[0] = '{1'b0,  7, 1'b0, 4'b0000, 4, 0,  7, 1'b0, 1'b0};
    vecs[1] = '{1'b1,  5, 1'b0, 4'b1110, 1, 3,  5, 1'b0, 1'b1};
    vecs[2] = '{1'b0, -1, 1'b0, 4'b0000, 4, 0, 20, 1'b1, 1'b0};
    vecs[3] = '{1'b1, -1, 1'b0, 4'b1110, 1, 3, 20, 1'b1, 1'b1};
    vecs[4] = '{1'b0,  0, 1'b0, 4'b0000, 4, 0,  0, 1'b0, 1'b0};
    vecs[5] = '{1'b0,  7, 1'b1, 4'b0000, 4, 0,  7, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    chk("reset_flags", {55'd0, pwm_en, pwm_mode, pwm_reload, rd_pos, rd_neg, busy,
                        result_valid, rd_timeout, rd_dir}, 64'd0);
    chk("reset_counts", {n_a, n_b}, 64'd0);
    chk("reset_rd_cnt", 64'(rd_cnt), 64'd0);
    rst = 1'b1;

    for (int i = 0; i < 6; i++) run_conv(i, 1'b1);

    // Host stalls in DONE; a start pulse there must be ignored.
    run_conv(0, 1'b0);
    ok = 1;
    for (int c = 0; c < 5; c++) begin
      start = (c == 2);
      @(negedge clk);
      if (result_valid !== 1'b1 || busy !== 1'b1 || n_a !== 32'd4 || n_b !== 32'd0 ||
          rd_cnt !== 16'd7 || rd_dir !== 1'b0 || rd_timeout !== 1'b0) ok = 0;
    end
    start = 1'b0;
    chk("hold_stable", {63'd0, ok}, 64'd1);
    result_ready = 1'b1;
    @(negedge clk); result_ready = 1'b0;
    chk("hold_ack_idle", {62'd0, result_valid, busy}, 64'd0);
    repeat (3) @(negedge clk);
    chk("done_start_ignored", {62'd0, busy, pwm_en}, 64'd0);

    // Asynchronous reset in the middle of run-up period 2.
    @(negedge clk); comp = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (15) @(negedge clk);
    chk("pre_reset_n_a", 64'(n_a), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("midreset_flags", {55'd0, pwm_en, pwm_mode, pwm_reload, rd_pos, rd_neg, busy,
                           result_valid, rd_timeout, rd_dir}, 64'd0);
    chk("midreset_counts", {n_a, n_b}, 64'd0);
    @(negedge clk); rst = 1'b1;
    run_conv(0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
